// File: rtl/sdram_burst_scheduler.sv
// SDRAM burst command scheduler: arbitrates refresh, ring-buffer writes and reads,
// issuing one command at a time to the SDRAM engine over req/ack/done.
module sdram_burst_scheduler #(
    parameter int unsigned BURST_LEN   = 256,
    parameter logic [23:0] REGION_BASE = 24'h000000,
    parameter logic [23:0] REGION_END  = 24'h800000,
    parameter int unsigned REF_PERIOD  = 390
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_level,
    input  logic [9:0]  rd_fifo_room,
    input  logic        rd_enable,
    output logic        cmd_req,
    output logic [1:0]  cmd_type,
    output logic [23:0] cmd_addr,
    output logic [9:0]  cmd_len,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    output logic        buf_full,
    output logic        buf_empty,
    output logic        ref_miss,
    output logic        busy
);

    localparam int unsigned REGION_WORDS  = 32'(REGION_END - REGION_BASE);
    localparam int unsigned REGION_BURSTS = REGION_WORDS / BURST_LEN;
    localparam int unsigned FILL_W        = $clog2(REGION_BURSTS + 1);
    localparam int unsigned TIMER_W       = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    localparam logic [9:0]         LEN        = 10'(BURST_LEN);
    localparam logic [23:0]        STEP       = 24'(BURST_LEN);
    localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(REGION_BURSTS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REF_PERIOD - 1);

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_REFRESH = 2'b11;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        REQ       = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state;
    logic                 init_meta;
    logic                 init_sync;
    logic [23:0]          wr_ptr;
    logic [23:0]          rd_ptr;
    logic [FILL_W-1:0]    fill;
    logic [TIMER_W-1:0]   ref_timer;
    logic                 ref_pending;
    logic [1:0]           active_cmd;

    logic                 write_ok;
    logic                 read_ok;
    logic                 ref_expire;
    logic                 ref_ack;
    logic [23:0]          wr_ptr_next;
    logic [23:0]          rd_ptr_next;
    logic [FILL_W-1:0]    fill_inc;
    logic [FILL_W-1:0]    fill_dec;
    logic [1:0]           grant_type;
    logic [23:0]          grant_addr;
    logic [9:0]           grant_len;

    // Ring pointer step with wrap back to the region base.
    function automatic logic [23:0] advance(input logic [23:0] ptr);
        logic [23:0] nxt;
        nxt = ptr + STEP;
        if (nxt >= REGION_END) begin
            nxt = REGION_BASE;
        end
        return nxt;
    endfunction

    assign write_ok    = (wr_fifo_level >= LEN) && !buf_full;
    assign read_ok     = rd_enable && (rd_fifo_room >= LEN) && !buf_empty;
    assign ref_expire  = (state != WAIT_INIT) && (ref_timer == TIMER_LAST);
    assign ref_ack     = (state == REQ) && cmd_ack && (active_cmd == CMD_REFRESH);
    assign wr_ptr_next = advance(wr_ptr);
    assign rd_ptr_next = advance(rd_ptr);
    assign fill_inc    = fill + FILL_W'(1);
    assign fill_dec    = fill - FILL_W'(1);

    // Fixed-priority arbitration: refresh, then write, then read.
    always_comb begin
        grant_type = CMD_NONE;
        grant_addr = '0;
        grant_len  = '0;
        if (ref_pending) begin
            grant_type = CMD_REFRESH;
        end else if (write_ok) begin
            grant_type = CMD_WRITE;
            grant_addr = wr_ptr;
            grant_len  = LEN;
        end else if (read_ok) begin
            grant_type = CMD_READ;
            grant_addr = rd_ptr;
            grant_len  = LEN;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state       <= WAIT_INIT;
            init_meta   <= 1'b0;
            init_sync   <= 1'b0;
            wr_ptr      <= REGION_BASE;
            rd_ptr      <= REGION_BASE;
            fill        <= '0;
            ref_timer   <= '0;
            ref_pending <= 1'b0;
            active_cmd  <= CMD_NONE;
            cmd_req     <= 1'b0;
            cmd_type    <= CMD_NONE;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            buf_full    <= 1'b0;
            buf_empty   <= 1'b1;
            ref_miss    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            init_meta <= sdram_init_done;
            init_sync <= init_meta;

            if ((state == WAIT_INIT) || ref_expire) begin
                ref_timer <= '0;
            end else begin
                ref_timer <= ref_timer + TIMER_W'(1);
            end

            // An expiry coinciding with a refresh ack re-arms the request.
            if (ref_expire) begin
                ref_pending <= 1'b1;
                if (ref_pending) begin
                    ref_miss <= 1'b1;
                end
            end else if (ref_ack) begin
                ref_pending <= 1'b0;
            end

            case (state)
                WAIT_INIT: begin
                    if (init_sync) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!init_sync) begin
                        state <= WAIT_INIT;
                    end else if (grant_type != CMD_NONE) begin
                        state      <= REQ;
                        cmd_req    <= 1'b1;
                        cmd_type   <= grant_type;
                        cmd_addr   <= grant_addr;
                        cmd_len    <= grant_len;
                        active_cmd <= grant_type;
                        busy       <= 1'b1;
                    end
                end
                REQ: begin
                    if (cmd_ack) begin
                        state    <= WAIT_DONE;
                        cmd_req  <= 1'b0;
                        cmd_type <= CMD_NONE;
                    end
                end
                WAIT_DONE: begin
                    if (cmd_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        case (active_cmd)
                            CMD_WRITE: begin
                                wr_ptr    <= wr_ptr_next;
                                fill      <= fill_inc;
                                buf_full  <= (fill_inc == FILL_MAX);
                                buf_empty <= 1'b0;
                            end
                            CMD_READ: begin
                                rd_ptr    <= rd_ptr_next;
                                fill      <= fill_dec;
                                buf_full  <= 1'b0;
                                buf_empty <= (fill_dec == '0);
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state <= WAIT_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Bench for sdram_burst_scheduler: vector table, hand-built corner sequences and a
// randomized phase checked against a queue-based ring-buffer model.
module tb_sdram_burst_scheduler;

    localparam int BL   = 4;
    localparam int BASE = 0;
    localparam int ENDA = 16;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_room;
    logic        rd_enable;
    logic        cmd_req;
    logic [1:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic [9:0]  cmd_len;
    logic        cmd_ack;
    logic        cmd_done;
    logic        buf_full;
    logic        buf_empty;
    logic        ref_miss;
    logic        busy;

    bit hold_wr;
    bit hold_done;
    bit acked;
    int checks = 0;
    int errors = 0;

    sdram_burst_scheduler #(
        .BURST_LEN   (4),
        .REGION_BASE (24'h000000),
        .REGION_END  (24'h000010),
        .REF_PERIOD  (100)
    ) dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_room    (rd_fifo_room),
        .rd_enable       (rd_enable),
        .cmd_req         (cmd_req),
        .cmd_type        (cmd_type),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_ack         (cmd_ack),
        .cmd_done        (cmd_done),
        .buf_full        (buf_full),
        .buf_empty       (buf_empty),
        .ref_miss        (ref_miss),
        .busy            (busy)
    );

    always #5 clk_50m = ~clk_50m;

    // Engine model: ack on the first cycle a request is visible, done one cycle later.
    initial begin
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        acked    = 1'b0;
        forever begin
            @(negedge clk_50m);
            cmd_done = acked && !hold_done;
            acked    = 1'b0;
            cmd_ack  = 1'b0;
            if (cmd_req && !(hold_wr && cmd_type == 2'b01)) begin
                cmd_ack = 1'b1;
                acked   = 1'b1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(cmd_req),   0);
        chk({tag, "_type"},  32'(cmd_type),  0);
        chk({tag, "_addr"},  32'(cmd_addr),  0);
        chk({tag, "_len"},   32'(cmd_len),   0);
        chk({tag, "_full"},  32'(buf_full),  0);
        chk({tag, "_empty"}, 32'(buf_empty), 1);
        chk({tag, "_miss"},  32'(ref_miss),  0);
        chk({tag, "_busy"},  32'(busy),      0);
    endtask

    // Waits for the next write/read request; refresh requests on the way are checked and skipped.
    task automatic find_cmd(input int budget, output bit found, output logic [1:0] t,
                            output logic [23:0] a, output logic [9:0] l);
        found = 1'b0;
        t = 2'b00;
        a = '0;
        l = '0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_50m);
            if (cmd_req) begin
                if (cmd_type == 2'b11) begin
                    chk("refresh_addr", 32'(cmd_addr), 0);
                    chk("refresh_len",  32'(cmd_len),  0);
                end else begin
                    found = 1'b1;
                    t = cmd_type;
                    a = cmd_addr;
                    l = cmd_len;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk_50m);
            idle = !busy;
        end
        chk({name, "_idle"}, 32'(idle), 1);
    endtask

    task automatic expect_cmd(input string name, input int lvl, input bit en, input int room,
                              input logic [1:0] etype, input int eaddr, input bit wait_done);
        bit          found;
        logic [1:0]  t;
        logic [23:0] a;
        logic [9:0]  l;
        wr_fifo_level = 10'(lvl);
        rd_enable     = en;
        rd_fifo_room  = 10'(room);
        find_cmd((etype == 2'b00) ? 16 : 300, found, t, a, l);
        if (etype == 2'b00) begin
            chk({name, "_none"}, 32'(found), 0);
        end else begin
            chk({name, "_found"}, 32'(found), 1);
            chk({name, "_type"},  32'(t), 32'(etype));
            chk({name, "_addr"},  32'(a), 32'(eaddr));
            chk({name, "_len"},   32'(l), 32'(BL));
            if (wait_done) begin
                wait_idle(name);
            end
        end
    endtask

    typedef struct {
        int         lvl;
        bit         en;
        int         room;
        logic [1:0] etype;
        int         eaddr;
        bit         efull;
        bit         eempty;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit          stable;
        int          q[$];
        int          mwr;
        int          lvl;
        int          room;
        bit          en;
        bit          wok;
        bit          rok;
        logic [1:0]  et;
        int          ea;

        tbl[0]  = '{4, 1'b0, 0, 2'b01, 0,  1'b0, 1'b0};
        tbl[1]  = '{4, 1'b0, 0, 2'b01, 4,  1'b0, 1'b0};
        tbl[2]  = '{4, 1'b0, 0, 2'b01, 8,  1'b0, 1'b0};
        tbl[3]  = '{4, 1'b0, 0, 2'b01, 12, 1'b1, 1'b0};
        tbl[4]  = '{4, 1'b0, 0, 2'b00, 0,  1'b1, 1'b0};
        tbl[5]  = '{0, 1'b1, 8, 2'b10, 0,  1'b0, 1'b0};
        tbl[6]  = '{0, 1'b1, 8, 2'b10, 4,  1'b0, 1'b0};
        tbl[7]  = '{0, 1'b1, 8, 2'b10, 8,  1'b0, 1'b0};
        tbl[8]  = '{0, 1'b1, 8, 2'b10, 12, 1'b0, 1'b1};
        tbl[9]  = '{0, 1'b1, 8, 2'b00, 0,  1'b0, 1'b1};
        tbl[10] = '{4, 1'b0, 0, 2'b01, 0,  1'b0, 1'b0};
        tbl[11] = '{5, 1'b0, 0, 2'b01, 4,  1'b0, 1'b0};
        tbl[12] = '{4, 1'b1, 8, 2'b01, 8,  1'b0, 1'b0};
        tbl[13] = '{3, 1'b1, 3, 2'b00, 0,  1'b0, 1'b0};
        tbl[14] = '{3, 1'b1, 4, 2'b10, 0,  1'b0, 1'b0};
        tbl[15] = '{0, 1'b0, 9, 2'b00, 0,  1'b0, 1'b0};

        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_level = '0;
        rd_fifo_room = '0;
        rd_enable = 1'b0;
        hold_wr = 1'b0;
        hold_done = 1'b0;
        repeat (3) @(negedge clk_50m);
        chk_reset("reset");
        rst_n = 1'b1;

        repeat (5) begin
            @(negedge clk_50m);
            chk("pre_init_busy", 32'(busy), 0);
            chk("pre_init_req",  32'(cmd_req), 0);
        end
        sdram_init_done = 1'b1;
        repeat (8) begin
            @(negedge clk_50m);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_req",  32'(cmd_req), 0);
        end

        foreach (tbl[i]) begin
            expect_cmd($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].en, tbl[i].room,
                       tbl[i].etype, tbl[i].eaddr, 1'b1);
            chk($sformatf("vec%0d_full", i),  32'(buf_full),  32'(tbl[i].efull));
            chk($sformatf("vec%0d_empty", i), 32'(buf_empty), 32'(tbl[i].eempty));
        end

        // Stalled write ack: request must stay stable and refresh must be reported missed.
        hold_wr = 1'b1;
        expect_cmd("hold_w12", 4, 1'b1, 8, 2'b01, 12, 1'b0);
        chk("miss_before_hold", 32'(ref_miss), 0);
        stable = 1'b1;
        repeat (250) begin
            @(negedge clk_50m);
            stable &= cmd_req && (cmd_type == 2'b01) && (cmd_addr == 24'd12) && (cmd_len == 10'd4);
        end
        chk("hold_stable", 32'(stable), 1);
        chk("miss_after_hold", 32'(ref_miss), 1);
        hold_wr = 1'b0;
        wait_idle("hold_release");
        chk("after_w12_full", 32'(buf_full), 0);

        begin
            bit found_req;
            found_req = 1'b0;
            for (int i = 0; i < 20 && !found_req; i++) begin
                @(negedge clk_50m);
                found_req = cmd_req;
            end
            chk("prio_ref_found", 32'(found_req), 1);
            chk("prio_ref_type",  32'(cmd_type), 3);
            chk("prio_ref_addr",  32'(cmd_addr), 0);
            chk("prio_ref_len",   32'(cmd_len),  0);
            wait_idle("prio_ref");
        end
        expect_cmd("prio_w0", 4, 1'b1, 8, 2'b01, 0, 1'b1);
        chk("prio_w0_full", 32'(buf_full), 1);
        expect_cmd("full_r4", 4, 1'b1, 8, 2'b10, 4, 1'b1);
        chk("full_r4_full", 32'(buf_full), 0);
        expect_cmd("w4", 4, 1'b0, 0, 2'b01, 4, 1'b1);
        expect_cmd("r8", 0, 1'b1, 8, 2'b10, 8, 1'b1);

        // Reset while the write at address 8 waits for done.
        hold_done = 1'b1;
        expect_cmd("abort_w8", 4, 1'b0, 0, 2'b01, 8, 1'b0);
        @(negedge clk_50m);
        chk("abort_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk_50m);
        chk_reset("mid_reset");
        rst_n = 1'b1;
        hold_done = 1'b0;
        repeat (3) begin
            @(negedge clk_50m);
            chk("reinit_req",  32'(cmd_req), 0);
            chk("reinit_busy", 32'(busy), 0);
        end
        @(negedge clk_50m);
        chk("reinit_grant_req",  32'(cmd_req), 1);
        chk("reinit_grant_type", 32'(cmd_type), 1);
        chk("reinit_grant_addr", 32'(cmd_addr), 0);
        chk("reinit_grant_len",  32'(cmd_len), 4);
        wait_idle("reinit_w0");

        // Randomized traffic against a queue model of the ring.
        q = '{0};
        mwr = BASE + BL;
        for (int it = 0; it < 60; it++) begin
            lvl  = int'($urandom_range(0, 8));
            en   = 1'($urandom_range(0, 1));
            room = int'($urandom_range(0, 8));
            wok = (lvl >= BL) && (q.size() < (ENDA - BASE) / BL);
            rok = en && (room >= BL) && (q.size() > 0);
            et = 2'b00;
            ea = 0;
            if (wok) begin
                et = 2'b01;
                ea = mwr;
            end else if (rok) begin
                et = 2'b10;
                ea = q[0];
            end
            expect_cmd($sformatf("rand%0d", it), lvl, en, room, et, ea, 1'b1);
            if (et == 2'b01) begin
                q.push_back(mwr);
                mwr = (mwr + BL >= ENDA) ? BASE : mwr + BL;
            end else if (et == 2'b10) begin
                void'(q.pop_front());
            end
            chk($sformatf("rand%0d_full", it),  32'(buf_full),  32'(q.size() == (ENDA - BASE) / BL));
            chk($sformatf("rand%0d_empty", it), 32'(buf_empty), 32'(q.size() == 0));
        end
        chk("rand_no_miss", 32'(ref_miss), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
